// File: rtl/tinysoc_seq.sv
// tinysoc_seq: boot-load and run-control sequencer for the tinysoc 4-bit CPU.
// Fills the instruction memory from a narrow pin bus, two half-words per
// instruction, then gates the CPU enable in free-run or single-step mode.
// It halts on the reserved 11x opcodes and counts executed instructions.
module tinysoc_seq #(
  parameter int IMEM_AW = 3,
  parameter int HALF_W  = 6,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HALF_W-1:0]     ld_data,
  input  logic                  ld_valid,
  input  logic                  free_run,
  input  logic                  step_req,
  input  logic [2*HALF_W-1:0]   cpu_instr,
  output logic [IMEM_AW-1:0]    imem_w_addr,
  output logic [2*HALF_W-1:0]   imem_w_data,
  output logic                  imem_wr,
  output logic                  cpu_en,
  output logic                  loaded,
  output logic                  halted,
  output logic [CNT_W-1:0]      icount
);

  typedef enum logic [2:0] {
    LOAD_LO,
    LOAD_HI,
    IDLE,
    RUN,
    STEP,
    HALT
  } state_t;

  localparam logic [IMEM_AW-1:0] LAST_ADDR = {IMEM_AW{1'b1}};

  state_t              state;
  logic [IMEM_AW-1:0]  addr_q;
  logic [HALF_W-1:0]   lo_reg;
  logic                step_q;
  logic                step_edge;
  logic                halt_op;
  logic                unused_instr_bits;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Only the two top instruction bits matter for halt detection; opcode
  // types 110 and 111 both land in the 11 prefix.
  assign halt_op           = (cpu_instr[2*HALF_W-1 -: 2] == 2'b11);
  assign unused_instr_bits = ^cpu_instr[2*HALF_W-3:0];

  // A held step_req must produce only one step, so act on its rising edge.
  assign step_edge = step_req & ~step_q;

  // Write port is driven straight from the pins so the high half and the
  // write strobe land in the same cycle; the address is the word counter.
  assign imem_w_addr = addr_q;
  assign imem_w_data = {ld_data, lo_reg};

  // Combinational strobes: memory write in LOAD_HI, CPU enable in RUN/STEP
  // with the halt opcode masked in the same cycle it is presented.
  always_comb begin
    imem_wr = 1'b0;
    cpu_en  = 1'b0;
    case (state)
      LOAD_HI: imem_wr = ld_valid;
      RUN:     cpu_en  = free_run & ~halt_op;
      STEP:    cpu_en  = ~halt_op;
      default: begin
        imem_wr = 1'b0;
        cpu_en  = 1'b0;
      end
    endcase
  end

  // Sequencer state, load bookkeeping, status flags and executed count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD_LO;
      addr_q <= '0;
      lo_reg <= '0;
      step_q <= 1'b0;
      loaded <= 1'b0;
      halted <= 1'b0;
      icount <= '0;
    end else begin
      step_q <= step_req;

      if (cpu_en) begin
        icount <= sat_inc(icount);
      end

      case (state)
        LOAD_LO: begin
          if (ld_valid) begin
            lo_reg <= ld_data;
            state  <= LOAD_HI;
          end
        end

        LOAD_HI: begin
          if (ld_valid) begin
            if (addr_q == LAST_ADDR) begin
              loaded <= 1'b1;
              state  <= IDLE;
            end else begin
              addr_q <= addr_q + 1'b1;
              state  <= LOAD_LO;
            end
          end
        end

        IDLE: begin
          // free_run takes precedence; a coincident step edge is dropped.
          if (free_run) begin
            state <= RUN;
          end else if (step_edge) begin
            state <= STEP;
          end
        end

        RUN: begin
          if (halt_op) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (!free_run) begin
            state <= IDLE;
          end
        end

        STEP: begin
          if (halt_op) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            state <= IDLE;
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= LOAD_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinysoc_seq.sv
// tb_tinysoc_seq: self-checking bench for the tinysoc boot-load / run-control
// sequencer. Expected enables come from rules over the input history
// (free_run now and last cycle, step_req edges), the executed count is an
// unbounded integer clipped at the counter maximum, and the load image is a
// plain array of words.
module tb_tinysoc_seq;

  localparam int IMEM_AW = 3;
  localparam int HALF_W  = 6;
  localparam int CNT_W   = 8;
  localparam int DEPTH   = 1 << IMEM_AW;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [HALF_W-1:0]    ld_data;
  logic                 ld_valid;
  logic                 free_run;
  logic                 step_req;
  logic [2*HALF_W-1:0]  cpu_instr;
  logic [IMEM_AW-1:0]   imem_w_addr;
  logic [2*HALF_W-1:0]  imem_w_data;
  logic                 imem_wr;
  logic                 cpu_en;
  logic                 loaded;
  logic                 halted;
  logic [CNT_W-1:0]     icount;

  tinysoc_seq #(.IMEM_AW(IMEM_AW), .HALF_W(HALF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ld_data(ld_data), .ld_valid(ld_valid),
    .free_run(free_run), .step_req(step_req), .cpu_instr(cpu_instr),
    .imem_w_addr(imem_w_addr), .imem_w_data(imem_w_data), .imem_wr(imem_wr),
    .cpu_en(cpu_en), .loaded(loaded), .halted(halted), .icount(icount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int model_cnt = 0;
  logic [11:0] model_mem [DEPTH];

  function automatic logic [CNT_W-1:0] exp_count(input int n);
    return (n > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(n);
  endfunction

  function automatic logic [11:0] rand_nonhalt();
    logic [11:0] w;
    w = 12'($urandom);
    if (w[11:10] == 2'b11) w[11] = 1'b0;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_valid = 1'b0; free_run = 1'b0; step_req = 1'b0;
    ld_data = '0; cpu_instr = 12'h600;
    tick();
    rst = 1'b0;
    model_cnt = 0;
  endtask

  // Feeds a full image, low half first, with optional idle gaps, while
  // free_run/step_req wiggle randomly to show they have no effect yet.
  task automatic load_image(input bit gaps, input bit directed);
    int writes = 0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [11:0] w;
      w = directed ? (12'h600 | 12'(k)) : 12'($urandom);
      model_mem[k] = w;
      for (int h = 0; h < 2; h++) begin
        if (gaps) begin
          int ng = $urandom_range(0, 2);
          for (int g = 0; g < ng; g++) begin
            ld_valid = 1'b0; ld_data = HALF_W'($urandom);
            free_run = 1'($urandom); step_req = 1'($urandom);
            #1;
            checks++;
            if (imem_wr !== 1'b0) $display("FAIL load_gap_wr: got %b expected 0", imem_wr);
            else passed++;
            tick();
          end
        end
        ld_valid = 1'b1;
        ld_data  = (h == 1) ? w[11:6] : w[5:0];
        free_run = 1'($urandom); step_req = 1'($urandom);
        #1;
        checks++;
        if (imem_wr !== (h == 1)) $display("FAIL load_wr_strobe: got %b expected %b", imem_wr, (h == 1));
        else passed++;
        checks++;
        if (cpu_en !== 1'b0) $display("FAIL load_cpu_en: got %b expected 0", cpu_en);
        else passed++;
        if (h == 1) begin
          writes++;
          checks++;
          if (imem_w_addr !== IMEM_AW'(k) || imem_w_data !== model_mem[k])
            $display("FAIL load_wr_word: got addr %0d data %h expected addr %0d data %h",
                     imem_w_addr, imem_w_data, k, model_mem[k]);
          else passed++;
        end
        tick();
        checks++;
        if (loaded !== (k == DEPTH-1 && h == 1))
          $display("FAIL load_loaded: got %b expected %b", loaded, (k == DEPTH-1 && h == 1));
        else passed++;
      end
    end
    checks++;
    if (writes != DEPTH) $display("FAIL load_write_count: got %0d expected %0d", writes, DEPTH);
    else passed++;
    // Two quiet cycles leave the sequencer idle with no stale step edge.
    for (int q = 0; q < 2; q++) begin
      ld_valid = 1'b0; free_run = 1'b0; step_req = 1'b0;
      #1;
      checks++;
      if (cpu_en !== 1'b0) $display("FAIL load_quiet_en: got %b expected 0", cpu_en);
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    ld_valid = 1'b1; ld_data = HALF_W'($urandom); free_run = 1'b1; step_req = 1'b1;
    #1;
    checks++;
    if (imem_wr !== 1'b0) $display("FAIL reset_imem_wr: got %b expected 0", imem_wr); else passed++;
    checks++;
    if (cpu_en !== 1'b0) $display("FAIL reset_cpu_en: got %b expected 0", cpu_en); else passed++;
    checks++;
    if (loaded !== 1'b0) $display("FAIL reset_loaded: got %b expected 0", loaded); else passed++;
    checks++;
    if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else passed++;
    checks++;
    if (icount !== '0) $display("FAIL reset_icount: got %0d expected 0", icount); else passed++;
    ld_valid = 1'b0; free_run = 1'b0; step_req = 1'b0;
    tick();
  endtask

  task automatic test_load();
    load_image(1'b0, 1'b1);
    // Once loaded, further half-words are ignored.
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = HALF_W'($urandom);
      #1;
      checks++;
      if (imem_wr !== 1'b0) $display("FAIL load_after_loaded_wr: got %b expected 0", imem_wr); else passed++;
      tick();
      checks++;
      if (loaded !== 1'b1) $display("FAIL load_stays_loaded: got %b expected 1", loaded); else passed++;
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_load_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      ld_valid = 1'b1; ld_data = HALF_W'($urandom);
      #1;
      checks++;
      if (imem_wr !== (i % 2 == 0)) $display("FAIL partial_wr: got %b expected %b", imem_wr, (i % 2 == 0));
      else passed++;
      if (i % 2 == 0) begin
        checks++;
        if (imem_w_addr !== IMEM_AW'(i/2 - 1)) $display("FAIL partial_addr: got %0d expected %0d", imem_w_addr, i/2 - 1);
        else passed++;
      end
      tick();
    end
    do_reset();
    checks++;
    if (loaded !== 1'b0) $display("FAIL reload_loaded: got %b expected 0", loaded); else passed++;
    load_image(1'b1, 1'b0);
  endtask

  task automatic test_free_run();
    bit prev_fr = 1'b0;
    bit exp_en;
    int pulses = 0;
    for (int t = 0; t < 14; t++) begin
      free_run = (t < 11); step_req = 1'b0; cpu_instr = 12'h600;
      #1;
      exp_en = free_run & prev_fr;
      checks++;
      if (cpu_en !== exp_en) $display("FAIL free_run_en t=%0d: got %b expected %b", t, cpu_en, exp_en); else passed++;
      if (exp_en) begin model_cnt++; pulses++; end
      tick();
      checks++;
      if (icount !== exp_count(model_cnt)) $display("FAIL free_run_icount: got %0d expected %0d", icount, exp_count(model_cnt));
      else passed++;
      prev_fr = free_run;
    end
    checks++;
    if (pulses != 10 || icount !== 8'd10) $display("FAIL free_run_total: got %0d expected 10", icount); else passed++;
  endtask

  task automatic test_random_run();
    bit prev_fr = 1'b0;
    bit exp_en;
    for (int t = 0; t < 41; t++) begin
      free_run = (t == 40) ? 1'b0 : 1'($urandom);
      step_req = 1'b0; cpu_instr = rand_nonhalt();
      #1;
      exp_en = free_run & prev_fr;
      checks++;
      if (cpu_en !== exp_en) $display("FAIL random_run_en t=%0d: got %b expected %b", t, cpu_en, exp_en); else passed++;
      if (exp_en) model_cnt++;
      tick();
      checks++;
      if (icount !== exp_count(model_cnt)) $display("FAIL random_run_icount: got %0d expected %0d", icount, exp_count(model_cnt));
      else passed++;
      prev_fr = free_run;
    end
  endtask

  task automatic test_step();
    bit p1 = 1'b0, p2 = 1'b0;
    bit exp_en;
    bit pat [7] = '{1, 1, 1, 0, 1, 0, 0};
    int pulses = 0;
    int base = model_cnt;
    for (int t = 0; t < 41; t++) begin
      free_run = 1'b0; cpu_instr = rand_nonhalt();
      step_req = (t < 7) ? pat[t] : ((t > 38) ? 1'b0 : 1'($urandom));
      #1;
      exp_en = p1 & ~p2;
      checks++;
      if (cpu_en !== exp_en) $display("FAIL step_en t=%0d: got %b expected %b", t, cpu_en, exp_en); else passed++;
      if (exp_en) begin model_cnt++; if (t < 7) pulses++; end
      tick();
      checks++;
      if (icount !== exp_count(model_cnt)) $display("FAIL step_icount: got %0d expected %0d", icount, exp_count(model_cnt));
      else passed++;
      if (t == 6) begin
        checks++;
        if (pulses != 2 || icount !== exp_count(base + 2)) $display("FAIL step_two_pulses: got %0d expected %0d", icount, exp_count(base + 2));
        else passed++;
      end
      p2 = p1; p1 = step_req;
    end
  endtask

  task automatic test_simultaneous();
    bit fr_pat [7] = '{1, 1, 1, 1, 1, 0, 0};
    bit sr_pat [7] = '{1, 1, 0, 1, 0, 0, 0};
    bit exp_pat [7] = '{0, 1, 1, 1, 1, 0, 0};
    for (int t = 0; t < 7; t++) begin
      free_run = fr_pat[t]; step_req = sr_pat[t]; cpu_instr = 12'h600;
      #1;
      checks++;
      if (cpu_en !== exp_pat[t]) $display("FAIL simultaneous_en t=%0d: got %b expected %b", t, cpu_en, exp_pat[t]); else passed++;
      if (exp_pat[t]) model_cnt++;
      tick();
    end
    checks++;
    if (icount !== exp_count(model_cnt)) $display("FAIL simultaneous_icount: got %0d expected %0d", icount, exp_count(model_cnt));
    else passed++;
  endtask

  task automatic halted_quiet(input string tag);
    int held = model_cnt;
    for (int t = 0; t < 8; t++) begin
      free_run = 1'($urandom); step_req = 1'($urandom); cpu_instr = rand_nonhalt();
      #1;
      checks++;
      if (cpu_en !== 1'b0) $display("FAIL %s_halted_en: got %b expected 0", tag, cpu_en); else passed++;
      tick();
      checks++;
      if (halted !== 1'b1 || icount !== exp_count(held))
        $display("FAIL %s_halted_hold: got halted %b icount %0d expected 1 %0d", tag, halted, icount, exp_count(held));
      else passed++;
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || icount !== '0 || loaded !== 1'b0)
      $display("FAIL %s_reset_clears: got halted %b icount %0d loaded %b expected 0 0 0", tag, halted, icount, loaded);
    else passed++;
    load_image(1'b1, 1'b0);
  endtask

  task automatic test_halt_run();
    logic [11:0] instr_seq [3] = '{12'h600, 12'h600, 12'hC00};
    bit exp_pat [3] = '{0, 1, 0};
    for (int t = 0; t < 3; t++) begin
      free_run = 1'b1; step_req = 1'b0; cpu_instr = instr_seq[t];
      #1;
      checks++;
      if (cpu_en !== exp_pat[t]) $display("FAIL halt_run_en t=%0d: got %b expected %b", t, cpu_en, exp_pat[t]); else passed++;
      checks++;
      if (halted !== 1'b0) $display("FAIL halt_run_early: got %b expected 0", halted); else passed++;
      if (exp_pat[t]) model_cnt++;
      tick();
    end
    checks++;
    if (halted !== 1'b1 || icount !== exp_count(model_cnt))
      $display("FAIL halt_run_flag: got halted %b icount %0d expected 1 %0d", halted, icount, exp_count(model_cnt));
    else passed++;
    halted_quiet("run");
  endtask

  task automatic test_halt_step();
    // A halt opcode seen while idle does not halt anything.
    free_run = 1'b0; step_req = 1'b0; cpu_instr = 12'hC00;
    tick();
    checks++;
    if (halted !== 1'b0) $display("FAIL halt_idle_ignored: got %b expected 0", halted); else passed++;
    step_req = 1'b1; cpu_instr = 12'h600;
    #1;
    checks++;
    if (cpu_en !== 1'b0) $display("FAIL halt_step_edge_en: got %b expected 0", cpu_en); else passed++;
    tick();
    cpu_instr = 12'hE00;
    #1;
    checks++;
    if (cpu_en !== 1'b0) $display("FAIL halt_step_en: got %b expected 0", cpu_en); else passed++;
    tick();
    checks++;
    if (halted !== 1'b1 || icount !== exp_count(model_cnt))
      $display("FAIL halt_step_flag: got halted %b icount %0d expected 1 %0d", halted, icount, exp_count(model_cnt));
    else passed++;
    halted_quiet("step");
  endtask

  task automatic test_saturation();
    bit prev_fr = 1'b0;
    bit exp_en;
    for (int t = 0; t < 304; t++) begin
      free_run = (t < 302); step_req = 1'($urandom); cpu_instr = rand_nonhalt();
      #1;
      exp_en = free_run & prev_fr;
      checks++;
      if (cpu_en !== exp_en) $display("FAIL sat_en t=%0d: got %b expected %b", t, cpu_en, exp_en); else passed++;
      if (exp_en) model_cnt++;
      tick();
      checks++;
      if (icount !== exp_count(model_cnt)) $display("FAIL sat_icount t=%0d: got %0d expected %0d", t, icount, exp_count(model_cnt));
      else passed++;
      prev_fr = free_run;
    end
    checks++;
    if (icount !== 8'd255) $display("FAIL sat_final: got %0d expected 255", icount); else passed++;
  endtask

  initial begin
    rst = 1'b1; ld_data = '0; ld_valid = 1'b0; free_run = 1'b0;
    step_req = 1'b0; cpu_instr = 12'h600;
    test_reset();
    test_load();
    test_load_reset();
    test_free_run();
    test_random_run();
    test_step();
    test_simultaneous();
    test_halt_run();
    test_halt_step();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tinysoc_seq.md
# tinysoc_seq

Boot-load and run-control sequencer for the tinysoc 4-bit CPU. It fills the 8-entry, 12-bit instruction memory from a 6-bit pin bus, two half-words per instruction. It then gates the CPU `en` input in free-run or single-step mode, halts on the reserved opcodes 11x, and counts executed instructions. It sits between the top-level pins, the instruction `RegFileSingle` write port and the `CPU` `en`/`instr` signals.

## Interface
- `IMEM_AW`, default 3: instruction memory address width; depth is 2**IMEM_AW.
- `HALF_W`, default 6: load half-word width; an instruction word is 2*HALF_W bits.
- `CNT_W`, default 8: executed-instruction counter width.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ld_data`  in  HALF_W  load half-word, low half first.
- `ld_valid`  in  1  `ld_data` is valid this cycle; one half-word is consumed per cycle it is high.
- `free_run`  in  1  level; 1 selects continuous execution.
- `step_req`  in  1  a rising edge requests one instruction.
- `cpu_instr`  in  2*HALF_W  instruction currently presented to the CPU.
- `imem_w_addr`  out  IMEM_AW  instruction memory write address.
- `imem_w_data`  out  2*HALF_W  instruction memory write data, `{ld_data, lo_reg}`.
- `imem_wr`  out  1  instruction memory write enable; combinational.
- `cpu_en`  out  1  CPU enable; combinational.
- `loaded`  out  1  instruction memory fully loaded.
- `halted`  out  1  a halt opcode was reached.
- `icount`  out  CNT_W  count of cycles with `cpu_en`=1; saturating.

## Operation
- States: LOAD_LO, LOAD_HI, IDLE, RUN, STEP, HALT. Reset state is LOAD_LO.
- LOAD_LO: when `ld_valid`=1, capture `ld_data` into `lo_reg` and go to LOAD_HI.
- LOAD_HI: when `ld_valid`=1:
  - `imem_wr`=1 in this same cycle, with `imem_w_addr` = address counter and `imem_w_data` = `{ld_data, lo_reg}`.
  - If the counter equals 2**IMEM_AW-1: go to IDLE and set `loaded`.
  - Otherwise: increment the counter and go to LOAD_LO.
- `ld_valid` low in either load state: hold the state.
- `imem_wr` is 0 outside LOAD_HI.
- Step edge detection: `step_q` registers `step_req` every cycle in every state. `step_edge` = `step_req & ~step_q`.
- Halt opcode detection: `halt_op` = (`cpu_instr[11:10]` == 2'b11), covering types 110 and 111.
- IDLE:
  - `free_run`=1: go to RUN.
  - Else `step_edge`=1: go to STEP.
  - If both are present, `free_run` wins and the edge is discarded.
- RUN:
  - `cpu_en` = `free_run & ~halt_op`.
  - If `halt_op`=1: go to HALT. This takes priority over `free_run`.
  - Else if `free_run`=0: go to IDLE.
  - Step edges are ignored in RUN.
- STEP:
  - `cpu_en` = `~halt_op`, for exactly this one cycle.
  - Next state is HALT if `halt_op`=1, else IDLE.
- HALT: `cpu_en`=0 and `halted`=1. The only exit is `rst`.
- `icount` increments on every cycle with `cpu_en`=1 and holds at 2**CNT_W-1.
- The halting instruction is never executed and never counted.
- After `loaded`, `ld_valid` and `ld_data` are ignored.

## Timing
- Values after reset: `imem_wr`=0, `cpu_en`=0, `loaded`=0, `halted`=0, `icount`=0, address counter=0, `lo_reg`=0, `step_q`=0.
- Reset during load or run: everything returns to LOAD_LO at address 0 and loading restarts.
- This block does not clear instruction memory; memory reset is owned by `RegFileSingle`.
- Load throughput: 2 `ld_valid` cycles per word, 16 cycles minimum for depth 8.
- `loaded` rises on the clock edge that writes the last word.
- `cpu_en` first rises on the cycle after the edge that enters RUN or STEP. The minimum is 1 cycle after `free_run` is sampled high in IDLE.
- `free_run` deassertion in RUN: `cpu_en` drops in the same cycle (combinational) and the state returns to IDLE on the next edge.
- Step latency: `step_req` rises in cycle N, the state is STEP in cycle N+1, and `cpu_en`=1 only in cycle N+1.
  - A held `step_req` yields exactly one step.
  - The next step needs `step_req` low for at least one cycle, then high again.
- `halt_op` is evaluated on `cpu_instr` in the same cycle, so `cpu_en` is never high while a halt opcode is presented.

## Test plan
- Load: drive 16 `ld_valid` half-words with word k = 12'h600 | k (low half first). Required:
  - Exactly 8 `imem_wr` pulses at addresses 0..7 with data 12'h600..12'h607.
  - `loaded`=1 after the 16th half-word.
  - `cpu_en`=0 throughout.
- Load gaps and reset: insert `ld_valid`=0 gaps, then assert `rst` after 5 half-words. Required:
  - The next write goes to address 0, built from the first two half-words after reset.
  - Gaps cause no writes.
- Free run: hold `free_run`=1 for 10 cycles with `cpu_instr`=12'h600 (IMM), then drop it. Required:
  - `cpu_en`=1 for 10 cycles and 0 from the drop cycle onward.
  - `icount`=10 and the state returns to IDLE.
- Single step: hold `step_req` high for 3 cycles, drive it low, then pulse it again. Required:
  - Exactly 2 single-cycle `cpu_en` pulses and `icount`=2.
  - `step_req` and `free_run` rising in the same cycle enters RUN.
- Halt: in RUN, present `cpu_instr`=12'hC00 (type 110). Required:
  - `cpu_en`=0 in that cycle and `halted`=1 on the next cycle.
  - `icount` unchanged; subsequent `free_run` and `step_req` have no effect until `rst`.
  - Repeat in STEP with 12'hE00 (type 111) for the same result.
- Saturation: run 300 non-halt cycles. Required: `icount`=255 and held there.
